// File: rtl/conv_weight_loader.sv
// Weight-stream loader for one quantised conv layer: checks that 64-bit weight writes arrive in
// strict sequential order and routes them to kernel, bias and scale RAMs and a final misc register.
module conv_weight_loader #(
    parameter int unsigned DATA_WIDTH        = 8,
    parameter int unsigned WEIGHT_DATA_WIDTH = 64,
    parameter logic [31:0] WEIGHT_BASE_ADDR  = 32'h4000_0000,
    parameter int unsigned IN_CHANNEL        = 3,
    parameter int unsigned OUT_CHANNEL       = 24,
    parameter int unsigned KERNEL_SIZE       = 3,
    parameter int unsigned GROUPS            = 1,
    localparam int unsigned PACK         = WEIGHT_DATA_WIDTH / DATA_WIDTH,
    localparam int unsigned KERNEL_ELEMS =
        OUT_CHANNEL * (IN_CHANNEL / GROUPS) * KERNEL_SIZE * KERNEL_SIZE,
    localparam int unsigned KERNEL_NUM   = KERNEL_ELEMS / PACK,
    localparam int unsigned BIAS_NUM     = OUT_CHANNEL / 2,
    localparam int unsigned SCALE_NUM    = OUT_CHANNEL,
    localparam int unsigned WEIGHTS_NUM  = KERNEL_NUM + BIAS_NUM + SCALE_NUM + 1,
    localparam int unsigned KW = (KERNEL_NUM > 1) ? $clog2(KERNEL_NUM) : 1,
    localparam int unsigned BW = (BIAS_NUM > 1) ? $clog2(BIAS_NUM) : 1,
    localparam int unsigned SW = (SCALE_NUM > 1) ? $clog2(SCALE_NUM) : 1,
    localparam int unsigned CW = $clog2(WEIGHTS_NUM + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         wr_en,
    input  logic [31:0]                  wr_addr,
    input  logic [WEIGHT_DATA_WIDTH-1:0] wr_data,
    output logic                         kernel_we,
    output logic [KW-1:0]                kernel_waddr,
    output logic [WEIGHT_DATA_WIDTH-1:0] kernel_wdata,
    output logic                         bias_we,
    output logic [BW-1:0]                bias_waddr,
    output logic [WEIGHT_DATA_WIDTH-1:0] bias_wdata,
    output logic                         scale_we,
    output logic [SW-1:0]                scale_waddr,
    output logic [31:0]                  scale_wdata,
    output logic [WEIGHT_DATA_WIDTH-1:0] misc_q,
    output logic                         busy,
    output logic                         load_done,
    output logic                         load_err,
    output logic [CW-1:0]                word_cnt
);

    if ((IN_CHANNEL % GROUPS) != 0) begin : gen_chk_groups
        $fatal(1, "IN_CHANNEL must be a multiple of GROUPS");
    end
    if ((OUT_CHANNEL % 2) != 0) begin : gen_chk_out_even
        $fatal(1, "OUT_CHANNEL must be even (two biases per word)");
    end
    if ((KERNEL_ELEMS % PACK) != 0) begin : gen_chk_kernel_pack
        $fatal(1, "kernel weights do not pack into whole bus words");
    end

    typedef enum logic [2:0] {StIdle, StKernel, StBias, StScale, StMisc, StDone} state_e;

    state_e      state_q;
    logic [31:0] idx;
    logic [31:0] exp_addr;
    logic        in_load;
    logic        accept;

    assign idx      = 32'(word_cnt);
    assign exp_addr = WEIGHT_BASE_ADDR + (idx << 3);

    always_comb begin
        in_load = (state_q == StKernel) || (state_q == StBias) ||
                  (state_q == StScale)  || (state_q == StMisc);
        // start takes priority: a write in the same cycle is silently dropped
        accept  = wr_en && in_load && (wr_addr == exp_addr) && !load_err && !start;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            kernel_we    <= 1'b0;
            kernel_waddr <= '0;
            kernel_wdata <= '0;
            bias_we      <= 1'b0;
            bias_waddr   <= '0;
            bias_wdata   <= '0;
            scale_we     <= 1'b0;
            scale_waddr  <= '0;
            scale_wdata  <= '0;
            misc_q       <= '0;
            busy         <= 1'b0;
            load_done    <= 1'b0;
            load_err     <= 1'b0;
            word_cnt     <= '0;
        end else begin
            kernel_we <= 1'b0;
            bias_we   <= 1'b0;
            scale_we  <= 1'b0;
            if (start) begin
                state_q   <= StKernel;
                busy      <= 1'b1;
                word_cnt  <= '0;
                load_done <= 1'b0;
                load_err  <= 1'b0;
            end else if (accept) begin
                word_cnt <= word_cnt + CW'(1);
                case (state_q)
                    StKernel: begin
                        kernel_we    <= 1'b1;
                        kernel_waddr <= KW'(idx);
                        kernel_wdata <= wr_data;
                        if (idx == KERNEL_NUM - 1) state_q <= StBias;
                    end
                    StBias: begin
                        bias_we    <= 1'b1;
                        bias_waddr <= BW'(idx - KERNEL_NUM);
                        bias_wdata <= wr_data;
                        if (idx == KERNEL_NUM + BIAS_NUM - 1) state_q <= StScale;
                    end
                    StScale: begin
                        scale_we    <= 1'b1;
                        scale_waddr <= SW'(idx - KERNEL_NUM - BIAS_NUM);
                        scale_wdata <= wr_data[31:0];
                        if (idx == WEIGHTS_NUM - 2) state_q <= StMisc;
                    end
                    StMisc: begin
                        misc_q    <= wr_data;
                        load_done <= 1'b1;
                        busy      <= 1'b0;
                        state_q   <= StDone;
                    end
                    default: ;
                endcase
            end else if (wr_en) begin
                // out-of-order, post-error or idle write: sticky until next start
                load_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_conv_weight_loader.sv
// Bench for conv_weight_loader: default (dense) and depthwise instances, scoreboarded RAM writes.
module tb_conv_weight_loader;

    localparam logic [31:0] BASE = 32'h4000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // dense instance (defaults: KERNEL_NUM 81, WEIGHTS_NUM 118)
    logic        start = 0, wr_en = 0;
    logic [31:0] wr_addr = '0;
    logic [63:0] wr_data = '0;
    logic        kernel_we, bias_we, scale_we, busy, load_done, load_err;
    logic [6:0]  kernel_waddr, word_cnt;
    logic [3:0]  bias_waddr;
    logic [4:0]  scale_waddr;
    logic [63:0] kernel_wdata, bias_wdata, misc_q;
    logic [31:0] scale_wdata;

    // depthwise instance (KERNEL_NUM 27, WEIGHTS_NUM 64)
    logic        dw_start = 0, dw_wr_en = 0;
    logic [31:0] dw_wr_addr = '0;
    logic [63:0] dw_wr_data = '0;
    logic        dw_kernel_we, dw_bias_we, dw_scale_we, dw_busy, dw_load_done, dw_load_err;
    logic [4:0]  dw_kernel_waddr, dw_scale_waddr;
    logic [3:0]  dw_bias_waddr;
    logic [6:0]  dw_word_cnt;
    logic [63:0] dw_kernel_wdata, dw_bias_wdata, dw_misc_q;
    logic [31:0] dw_scale_wdata;

    conv_weight_loader u_dut (
        .clk(clk), .rst(rst), .start(start), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .kernel_we(kernel_we), .kernel_waddr(kernel_waddr),
        .kernel_wdata(kernel_wdata), .bias_we(bias_we), .bias_waddr(bias_waddr),
        .bias_wdata(bias_wdata), .scale_we(scale_we), .scale_waddr(scale_waddr),
        .scale_wdata(scale_wdata), .misc_q(misc_q), .busy(busy), .load_done(load_done),
        .load_err(load_err), .word_cnt(word_cnt)
    );

    conv_weight_loader #(.IN_CHANNEL(24), .OUT_CHANNEL(24), .KERNEL_SIZE(3), .GROUPS(24)) u_dw (
        .clk(clk), .rst(rst), .start(dw_start), .wr_en(dw_wr_en), .wr_addr(dw_wr_addr),
        .wr_data(dw_wr_data), .kernel_we(dw_kernel_we), .kernel_waddr(dw_kernel_waddr),
        .kernel_wdata(dw_kernel_wdata), .bias_we(dw_bias_we), .bias_waddr(dw_bias_waddr),
        .bias_wdata(dw_bias_wdata), .scale_we(dw_scale_we), .scale_waddr(dw_scale_waddr),
        .scale_wdata(dw_scale_wdata), .misc_q(dw_misc_q), .busy(dw_busy),
        .load_done(dw_load_done), .load_err(dw_load_err), .word_cnt(dw_word_cnt)
    );

    typedef struct {
        logic [2:0]  kind;  // {kernel, bias, scale}
        logic [63:0] addr;
        logic [63:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t dsb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   dw_k_before = 0;
    bit   dw_seen_bias = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference region map: which RAM and which local address word idx belongs to.
    task automatic push(input bit dw, input int unsigned idx, input logic [63:0] data);
        int unsigned k = dw ? 27 : 81;
        int unsigned b = 12;
        int unsigned s = 24;
        exp_t e;
        if (idx < k) begin
            e.kind = 3'b100; e.addr = 64'(idx); e.data = data;
        end else if (idx < k + b) begin
            e.kind = 3'b010; e.addr = 64'(idx - k); e.data = data;
        end else if (idx < k + b + s) begin
            e.kind = 3'b001; e.addr = 64'(idx - k - b); e.data = {32'h0, data[31:0]};
        end else begin
            return;  // misc word has no write pulse
        end
        if (dw) dsb.push_back(e);
        else sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en    = 1'b0;
        dw_wr_en = 1'b0;
    endtask

    task automatic write_w(input bit dw, input int unsigned idx, input logic [31:0] addr,
                           input logic [63:0] data, input bit acc);
        if (dw) begin
            dw_wr_en = 1'b1; dw_wr_addr = addr; dw_wr_data = data;
        end else begin
            wr_en = 1'b1; wr_addr = addr; wr_data = data;
        end
        if (acc) push(dw, idx, data);
        tick();
    endtask

    task automatic pulse_start(input bit dw);
        if (dw) dw_start = 1'b1;
        else start = 1'b1;
        tick();
        start    = 1'b0;
        dw_start = 1'b0;
    endtask

    task automatic load_all(input bit dw, input int unsigned n, input logic [63:0] off);
        for (int unsigned i = 0; i < n; i++) write_w(dw, i, BASE + 32'(8 * i), off + 64'(i), 1'b1);
        idle();
        tick();
    endtask

    always @(negedge clk) begin
        exp_t        e;
        logic [63:0] oa, od;
        if (kernel_we || bias_we || scale_we) begin
            if (sb.size() == 0) begin
                check("unexpected_we", 64'({kernel_we, bias_we, scale_we}), 64'd0);
            end else begin
                e = sb.pop_front();
                check("we_select", 64'({kernel_we, bias_we, scale_we}), 64'(e.kind));
                case (e.kind)
                    3'b100:  begin oa = 64'(kernel_waddr); od = kernel_wdata; end
                    3'b010:  begin oa = 64'(bias_waddr);   od = bias_wdata;   end
                    default: begin oa = 64'(scale_waddr);  od = 64'(scale_wdata); end
                endcase
                check("waddr", oa, e.addr);
                check("wdata", od, e.data);
            end
        end
    end

    always @(negedge clk) begin
        exp_t        e;
        logic [63:0] oa, od;
        if (dw_kernel_we && !dw_seen_bias) dw_k_before++;
        if (dw_bias_we) dw_seen_bias = 1'b1;
        if (dw_kernel_we || dw_bias_we || dw_scale_we) begin
            if (dsb.size() == 0) begin
                check("dw_unexpected_we", 64'({dw_kernel_we, dw_bias_we, dw_scale_we}), 64'd0);
            end else begin
                e = dsb.pop_front();
                check("dw_we_select", 64'({dw_kernel_we, dw_bias_we, dw_scale_we}), 64'(e.kind));
                case (e.kind)
                    3'b100:  begin oa = 64'(dw_kernel_waddr); od = dw_kernel_wdata; end
                    3'b010:  begin oa = 64'(dw_bias_waddr);   od = dw_bias_wdata;   end
                    default: begin oa = 64'(dw_scale_waddr);  od = 64'(dw_scale_wdata); end
                endcase
                check("dw_waddr", oa, e.addr);
                check("dw_wdata", od, e.data);
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(load_done), 64'd0);
        check("rst_err", 64'(load_err), 64'd0);
        check("rst_cnt", 64'(word_cnt), 64'd0);
        check("rst_misc", misc_q, 64'd0);
        check("rst_we", 64'({kernel_we, bias_we, scale_we}), 64'd0);
        rst = 1'b0;
        tick();

        // full dense load, data = index
        pulse_start(0);
        check("start_busy", 64'(busy), 64'd1);
        load_all(0, 118, 64'd0);
        check("full_misc", misc_q, 64'd117);
        check("full_done", 64'(load_done), 64'd1);
        check("full_err", 64'(load_err), 64'd0);
        check("full_cnt", 64'(word_cnt), 64'd118);
        check("full_busy", 64'(busy), 64'd0);
        check("full_drained", 64'(sb.size()), 64'd0);

        // write after done
        write_w(0, 118, 32'h4000_03B0, 64'hDEAD_BEEF, 1'b0);
        idle();
        tick();
        check("after_done_err", 64'(load_err), 64'd1);
        check("after_done_misc", misc_q, 64'd117);
        check("after_done_hold", 64'(load_done), 64'd1);

        // skipped address on the 5th write
        pulse_start(0);
        check("restart_err_clr", 64'(load_err), 64'd0);
        for (int unsigned i = 0; i < 4; i++) write_w(0, i, BASE + 32'(8 * i), 64'(i + 500), 1'b1);
        write_w(0, 4, 32'h4000_0030, 64'd504, 1'b0);
        check("skip_err", 64'(load_err), 64'd1);
        for (int unsigned i = 5; i < 8; i++) write_w(0, i, BASE + 32'(8 * i), 64'(i + 500), 1'b0);
        idle();
        tick();
        check("skip_cnt", 64'(word_cnt), 64'd4);
        check("skip_busy", 64'(busy), 64'd1);
        check("skip_drained", 64'(sb.size()), 64'd0);

        // start and write in the same cycle: write dropped
        start   = 1'b1;
        wr_en   = 1'b1;
        wr_addr = BASE;
        wr_data = 64'hFF;
        tick();
        start = 1'b0;
        idle();
        check("collide_err", 64'(load_err), 64'd0);
        check("collide_cnt", 64'(word_cnt), 64'd0);
        write_w(0, 0, BASE, 64'hA5, 1'b1);
        idle();
        tick();
        check("collide_next_cnt", 64'(word_cnt), 64'd1);
        check("collide_drained", 64'(sb.size()), 64'd0);

        // reset at word 50, then full reload
        pulse_start(0);
        for (int unsigned i = 0; i < 50; i++) write_w(0, i, BASE + 32'(8 * i), 64'(i), 1'b1);
        idle();
        tick();
        rst = 1'b1;
        #1;
        check("midrst_cnt", 64'(word_cnt), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_misc", misc_q, 64'd0);
        tick();
        rst = 1'b0;
        tick();
        pulse_start(0);
        load_all(0, 118, 64'h100);
        check("reload_done", 64'(load_done), 64'd1);
        check("reload_err", 64'(load_err), 64'd0);
        check("reload_cnt", 64'(word_cnt), 64'd118);
        check("reload_misc", misc_q, 64'h100 + 64'd117);
        check("reload_drained", 64'(sb.size()), 64'd0);

        // depthwise layer: first bias on the write to 0x4000_00D8 (word 27)
        pulse_start(1);
        load_all(1, 64, 64'h1000);
        check("dw_k_before_bias", 64'(dw_k_before), 64'd27);
        check("dw_done", 64'(dw_load_done), 64'd1);
        check("dw_err", 64'(dw_load_err), 64'd0);
        check("dw_cnt", 64'(dw_word_cnt), 64'd64);
        check("dw_misc", dw_misc_q, 64'h1000 + 64'd63);
        check("dw_drained", 64'(dsb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/conv_weight_loader.md
Name: conv_weight_loader

Overview:
- Parametrised weight-stream loader for one quantised conv layer of the ShuffleNet accelerator.
- Accepts 64-bit memory-mapped weight writes and checks that they arrive in strict sequential order. Each accepted word is routed to one of four destinations: kernel RAM, bias RAM, dequant-scale RAM, or a final misc register.
- Generalises the fixed layer constants to any channel count, kernel size and group count, so depthwise layers are covered.
- Adds order checking, completion and error status.

Parameters:
- DATA_WIDTH, 8: weight element width in bits.
- WEIGHT_DATA_WIDTH, 64: width of the input bus word.
- WEIGHT_BASE_ADDR, 32'h4000_0000: byte address of word 0.
- IN_CHANNEL, 3: input channels.
- OUT_CHANNEL, 24: output channels.
- KERNEL_SIZE, 3: square kernel side length.
- GROUPS, 1: convolution groups. 1 = dense; GROUPS = IN_CHANNEL = OUT_CHANNEL = depthwise.
- Derived, KERNEL_NUM = OUT_CHANNEL*(IN_CHANNEL/GROUPS)*KERNEL_SIZE^2 / (WEIGHT_DATA_WIDTH/DATA_WIDTH). Default 81.
- Derived, BIAS_NUM = OUT_CHANNEL/2. Default 12.
- Derived, SCALE_NUM = OUT_CHANNEL. Default 24.
- Derived, WEIGHTS_NUM = KERNEL_NUM+BIAS_NUM+SCALE_NUM+1. Default 118.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; arms a new load.
- wr_en  in  1  write strobe.
- wr_addr  in  32  byte address, 8-byte aligned.
- wr_data  in  64  weight word.
- kernel_we  out  1  kernel RAM write enable.
- kernel_waddr  out  clog2(KERNEL_NUM)  kernel RAM word address.
- kernel_wdata  out  64  eight packed int8 weights.
- bias_we  out  1  bias RAM write enable.
- bias_waddr  out  clog2(BIAS_NUM)  bias RAM word address.
- bias_wdata  out  64  two int32 biases; low half = even channel.
- scale_we  out  1  dequant-scale RAM write enable.
- scale_waddr  out  clog2(SCALE_NUM)  scale RAM word address.
- scale_wdata  out  32  wr_data[31:0].
- misc_q  out  64  final-word register (output quant params).
- busy  out  1  load in progress.
- load_done  out  1  all WEIGHTS_NUM words accepted.
- load_err  out  1  sticky protocol error.
- word_cnt  out  clog2(WEIGHTS_NUM+1)  number of words accepted.

Behaviour:
- Reset (async, rst=1): all outputs and counters go to 0 and the FSM goes to IDLE.
- FSM states: IDLE, KERNEL, BIAS, SCALE, MISC, DONE.
- start in any state: clears word_cnt, load_done and load_err; FSM goes to KERNEL; busy=1 next cycle.
  - If wr_en is high in the same cycle as start, start wins and the write is dropped with no error.
- Expected address = WEIGHT_BASE_ADDR + 8*word_cnt.
- A write is accepted when all of the following hold: wr_en=1, FSM is in KERNEL/BIAS/SCALE/MISC, wr_addr equals the expected address, load_err=0.
- Accepted write, region by index i = word_cnt:
  - KERNEL (i < KERNEL_NUM): kernel_we=1, kernel_waddr=i.
  - BIAS: bias_we=1, bias_waddr = i-KERNEL_NUM.
  - SCALE: scale_we=1, scale_waddr = i-KERNEL_NUM-BIAS_NUM.
  - MISC: misc_q <= wr_data.
- Output timing: the write-enable, address and data outputs are registered with exactly 1-cycle latency from the wr_en cycle. Write enables are single-cycle pulses, and at most one is high per cycle.
- State advance: when the last word of a region is accepted, the FSM advances to the next region. Accepting the MISC word sets load_done=1 (same cycle as the misc_q update), clears busy, and moves the FSM to DONE. load_done holds until the next start or reset.
- Rejected write while busy (address mismatch, including a repeated or skipped address): load_err=1. busy stays 1, but no further writes are accepted until the next start.
- wr_en in IDLE or DONE: ignored, load_err set.
- Back-to-back writes are accepted every cycle with no stall. This block has no ready signal; upstream must not exceed one write per cycle.
- Reset mid-load: everything clears immediately. Downstream RAM contents are not invalidated; load_done=0 marks them stale.
- Elaboration checks, each a fatal error on failure:
  - IN_CHANNEL % GROUPS == 0
  - OUT_CHANNEL even
  - KERNEL_NUM an exact integer (no remainder)

Test Plan:
- Default params: start, then 118 sequential writes with data = index, addresses 0x4000_0000 .. 0x4000_03A8. Required response:
  - 81 kernel_we pulses with addr 0..80.
  - 12 bias_we pulses with addr 0..11, data 81..92.
  - 24 scale_we pulses with scale_wdata 93..116.
  - misc_q = 117, load_done=1, load_err=0, word_cnt=118.
- Skipped address: the 5th write goes to 0x4000_0030 instead of 0x4000_0020 → load_err=1 one cycle later. No we pulse for it or for any later write. word_cnt stays 4.
- Write after done: one more write to 0x4000_03B0 → load_err=1, misc_q unchanged.
- Depthwise: GROUPS=IN_CHANNEL=OUT_CHANNEL=24, KERNEL_SIZE=3, so KERNEL_NUM=27 and WEIGHTS_NUM=64. The first bias_we must occur on the write to 0x4000_00D8.
- start in the same cycle as wr_en to the base address → write dropped, no kernel_we. Next write to the base address accepted, kernel_waddr=0.
- Assert rst for 1 cycle at word 50, then start and a full reload → clean completion with load_done=1 and load_err=0.
